// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: CPU writes fill a FIFO, a baud FSM drains it.
// Ports: sys_clk_i/sys_rst_i (sync, active-low), uart_wr_i/uart_dat_i push a byte,
// uart_rd_i clears overflow, uart_data_o status word, uart_tx_o serial line.
module uart_tx_fifo #(
  parameter int BAUDRATE = 115200,
  parameter int F_CLK    = 50000000,
  parameter int DEPTH    = 8
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        uart_wr_i,
  input  logic [7:0]  uart_dat_i,
  input  logic        uart_rd_i,
  output logic [31:0] uart_data_o,
  output logic        uart_tx_o
);

  localparam int DIV = F_CLK / BAUDRATE;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: F_CLK / BAUDRATE must be >= 2");
  end

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 in 2..8");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;

  logic full;
  logic empty;
  logic baud_last;
  logic pop;
  logic push;
  logic ovf_set;

  assign full      = count == CW'(DEPTH);
  assign empty     = count == '0;
  assign baud_last = baud_cnt == BW'(DIV - 1);

  // Pop when idle, or on the last stop cycle so frames run back to back.
  assign pop = !empty &&
               (state == IDLE || (state == STOP && baud_last));

  // A pop in the same cycle frees a slot, so a write into a full FIFO
  // is still accepted then.
  assign push    = uart_wr_i && (!full || pop);
  assign ovf_set = uart_wr_i && full && !pop;

  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= uart_dat_i;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count + CW'(push) - CW'(pop);
      // Set wins over a same-cycle status read.
      overflow <= ovf_set | (overflow & ~uart_rd_i);
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state     <= IDLE;
      uart_tx_o <= 1'b1;
      shift     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          uart_tx_o <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            bit_cnt  <= '0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          uart_tx_o <= 1'b0;
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          uart_tx_o <= shift[0];
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          uart_tx_o <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              bit_cnt <= '0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    uart_data_o          = '0;
    uart_data_o[0]       = (state != IDLE) | ~empty;
    uart_data_o[1]       = full;
    uart_data_o[2]       = empty;
    uart_data_o[3]       = overflow;
    uart_data_o[8 +: CW] = count;
  end

endmodule
